// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Each op is busy for WIDTH+1 cycles, then done pulses.
// Requests are not queued: start, MTHI and MTLO are taken only while idle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic [WIDTH-1:0] hi_in,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] lo_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  typedef struct packed {
    logic is_div;
    logic neg_q;   // negate product (mult) or quotient (div)
    logic neg_r;   // remainder follows the dividend's sign
    logic b_zero;
  } ctx_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic [WIDTH-1:0]   aorig_q, aorig_d;
  ctx_t               ctx_q, ctx_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // acc holds {partial product, multiplier} for mult and {remainder, dividend/quotient} for div
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge    = div_shift >= {1'b0, bmag_q};
    div_sub   = div_shift[WIDTH-1:0] - bmag_q;
    div_next  = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    prod      = ctx_q.neg_q ? -acc_q : acc_q;
    quot      = ctx_q.neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem       = ctx_q.neg_r ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bmag_d  = bmag_q;
    aorig_d = aorig_q;
    ctx_d   = ctx_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = hi_in;
        if (lo_we) lo_d = lo_in;
        if (start) begin
          state_d      = CALC;
          cnt_d        = '0;
          acc_d        = {{WIDTH{1'b0}}, a_mag};
          bmag_d       = b_mag;
          aorig_d      = a;
          ctx_d.is_div = op[1];
          ctx_d.neg_q  = a_neg ^ b_neg;
          ctx_d.neg_r  = a_neg;
          ctx_d.b_zero = (b == '0);
          if (op[1]) dz_d = (b == '0);
        end
      end
      CALC: begin
        acc_d = ctx_q.is_div ? div_next : mul_next;
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIX: begin
        // Zero divisor yields all-ones quotient and the untouched dividend as remainder
        if (!ctx_q.is_div) begin
          {hi_d, lo_d} = prod;
        end else if (ctx_q.b_zero) begin
          hi_d = aorig_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      bmag_q  <= '0;
      aorig_q <= '0;
      ctx_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bmag_q  <= bmag_d;
      aorig_q <= aorig_d;
      ctx_q   <= ctx_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: 32-bit and 8-bit instances, directed vectors with hand-computed results.
module tb_muldiv_unit;

  logic        clk, rst;
  logic        start32, hi_we32, lo_we32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, hi_in32, lo_in32;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        start8, hi_we8, lo_we8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi_in8, lo_in8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   brun32 = 0;
  int   brun8 = 0;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
    .hi_we(hi_we32), .hi_in(hi_in32), .lo_we(lo_we32), .lo_in(lo_in32),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi_we(hi_we8), .hi_in(hi_in8), .lo_we(lo_we8), .lo_in(lo_in8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at 300000 time units");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept happens at the next edge; done is observed at the negedge after WIDTH+1 more edges
  task automatic issue32(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz,
                         input bit push);
    start32 = 1'b1;
    op32    = o;
    a32     = av;
    b32     = bv;
    if (push) q32.push_back('{eh, el, edz, cyc + 34});
    step();
    start32 = 1'b0;
  endtask

  task automatic issue8(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] eh, input logic [7:0] el, input logic edz);
    start8 = 1'b1;
    op8    = o;
    a8     = av;
    b8     = bv;
    q8.push_back('{{24'b0, eh}, {24'b0, el}, edz, cyc + 10});
    step();
    start8 = 1'b0;
  endtask

  task automatic wait_done(input bit w8, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = w8 ? done8 : done32;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: done not seen within 100 cycles, required done=1", nm);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      brun32 = 0;
    end else begin
      if (done32) begin
        if (q32.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL done32_unexpected: got done=1, required no pending op");
        end else begin
          e32 = q32.pop_front();
          chk("res32_hi", hi32, e32.hi);
          chk("res32_lo", lo32, e32.lo);
          chk("res32_div_zero", {31'b0, dz32}, {31'b0, e32.dz});
          chk("res32_done_cycle", cyc, e32.cyc);
          chk("res32_busy_cycles", brun32, 33);
        end
        brun32 = 0;
      end
      if (busy32) brun32++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      brun8 = 0;
    end else begin
      if (done8) begin
        if (q8.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL done8_unexpected: got done=1, required no pending op");
        end else begin
          e8 = q8.pop_front();
          chk("res8_hi", {24'b0, hi8}, e8.hi);
          chk("res8_lo", {24'b0, lo8}, e8.lo);
          chk("res8_div_zero", {31'b0, dz8}, {31'b0, e8.dz});
          chk("res8_done_cycle", cyc, e8.cyc);
          chk("res8_busy_cycles", brun8, 9);
        end
        brun8 = 0;
      end
      if (busy8) brun8++;
    end
  end

  initial begin
    rst = 1'b1;
    start32 = 1'b1; op32 = 2'b01; a32 = 32'd5; b32 = 32'd5;
    hi_we32 = 1'b0; lo_we32 = 1'b0; hi_in32 = '0; lo_in32 = '0;
    start8 = 1'b1; op8 = 2'b11; a8 = 8'd9; b8 = 8'd2;
    hi_we8 = 1'b0; lo_we8 = 1'b0; hi_in8 = '0; lo_in8 = '0;
    step();
    step();
    rst = 1'b0;
    start32 = 1'b0;
    start8 = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi32, 32'h0);
    chk("reset_lo", lo32, 32'h0);
    chk("reset_busy", {31'b0, busy32}, 32'h0);
    chk("reset_done", {31'b0, done32}, 32'h0);
    chk("reset_div_zero", {31'b0, dz32}, 32'h0);
    chk("reset_busy8", {31'b0, busy8}, 32'h0);
    step();

    // Signed/unsigned multiply and divide, sign rules, zero divisor, overflow
    issue32(2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b1);
    wait_done(1'b0, "mult_neg2_x3");
    issue32(2'b00, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 1'b0, 1'b1);
    wait_done(1'b0, "multu_fffffffe_x3");
    issue32(2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1);
    wait_done(1'b0, "div_neg7_by2");
    issue32(2'b10, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 1'b1);
    wait_done(1'b0, "divu_7_by2");
    issue32(2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b1);
    wait_done(1'b0, "divu_by_zero");
    issue32(2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b1, 1'b1);
    wait_done(1'b0, "multu_keeps_div_zero");
    issue32(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b1);
    wait_done(1'b0, "div_overflow");
    issue32(2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b1);
    wait_done(1'b0, "div_signed_by_zero");
    issue32(2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b1);
    wait_done(1'b0, "div_7_by_neg2");

    // start re-pulsed mid-op must be ignored
    step();
    issue32(2'b00, 32'd6, 32'd7, 32'h0, 32'h0000002A, 1'b0, 1'b1);
    repeat (5) step();
    start32 = 1'b1; op32 = 2'b10; a32 = 32'd100; b32 = 32'd0;
    step();
    start32 = 1'b0;
    wait_done(1'b0, "repulse_ignored");

    // start accepted in the done cycle
    step();
    issue32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h00000001, 1'b0, 1'b1);
    wait_done(1'b0, "mult_neg1_sq");
    issue32(2'b10, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 1'b1);
    wait_done(1'b0, "divu_back_to_back");

    // MTHI/MTLO while busy and in the FIX cycle lose to the op result
    step();
    issue32(2'b00, 32'd3, 32'd5, 32'h0, 32'h0000000F, 1'b0, 1'b1);
    repeat (3) step();
    hi_we32 = 1'b1; hi_in32 = 32'hDEADBEEF; lo_we32 = 1'b1; lo_in32 = 32'hCAFEF00D;
    step();
    hi_we32 = 1'b0; lo_we32 = 1'b0;
    repeat (28) step();
    hi_we32 = 1'b1; hi_in32 = 32'hDEADBEEF; lo_we32 = 1'b1; lo_in32 = 32'hCAFEF00D;
    step();
    hi_we32 = 1'b0; lo_we32 = 1'b0;
    wait_done(1'b0, "mthi_while_busy");

    step();
    hi_we32 = 1'b1; hi_in32 = 32'hA5A5A5A5;
    step();
    hi_we32 = 1'b0;
    @(negedge clk);
    chk("mthi_idle_hi", hi32, 32'hA5A5A5A5);
    chk("mthi_idle_lo_kept", lo32, 32'h0000000F);
    step();
    lo_we32 = 1'b1; lo_in32 = 32'h5A5A5A5A;
    step();
    lo_we32 = 1'b0;
    @(negedge clk);
    chk("mtlo_idle_lo", lo32, 32'h5A5A5A5A);
    chk("mtlo_idle_hi_kept", hi32, 32'hA5A5A5A5);

    // Same-cycle start and MTHI: write lands now, result overwrites later
    step();
    hi_we32 = 1'b1; hi_in32 = 32'h11111111;
    issue32(2'b00, 32'd2, 32'd2, 32'h0, 32'h00000004, 1'b0, 1'b1);
    hi_we32 = 1'b0;
    @(negedge clk);
    chk("start_with_mthi_hi", hi32, 32'h11111111);
    chk("start_with_mthi_busy", {31'b0, busy32}, 32'h1);
    wait_done(1'b0, "start_with_mthi");

    // Reset at iteration 10 aborts without writing hi/lo or pulsing done
    step();
    issue32(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy32}, 32'h0);
    chk("abort_hi", hi32, 32'h0);
    chk("abort_lo", lo32, 32'h0);
    chk("abort_done", {31'b0, done32}, 32'h0);
    repeat (45) step();
    @(negedge clk);
    chk("abort_hi_later", hi32, 32'h0);
    chk("abort_lo_later", lo32, 32'h0);

    // WIDTH=8 instance
    step();
    issue8(2'b01, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0);
    wait_done(1'b1, "w8_mult_min_sq");
    issue8(2'b11, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
    wait_done(1'b1, "w8_div_overflow");
    issue8(2'b10, 8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0);
    wait_done(1'b1, "w8_divu_ff_by16");
    issue8(2'b10, 8'h05, 8'h00, 8'h05, 8'hFF, 1'b1);
    wait_done(1'b1, "w8_divu_by_zero");

    step();
    step();
    chk("q32_drained", q32.size(), 32'd0);
    chk("q8_drained", q8.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit, successor to the single-cycle combinational ALU.
- Handles MULT/MULTU/DIV/DIVU for the 54-instruction CPU, plus MTHI/MTLO register writes.
- Owns the HI/LO architectural registers.
- Sits beside the ALU in EX; the control unit stalls the pipeline while busy=1.

Parameters:
WIDTH, 32, operand width; hi/lo are WIDTH bits each; iteration count = WIDTH
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when busy=0
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
hi_we  input  1  MTHI write enable
hi_in  input  WIDTH  MTHI data
lo_we  input  1  MTLO write enable
lo_in  input  WIDTH  MTLO data
busy  output  1  operation in progress
done  output  1  one-cycle pulse: hi/lo just updated by an op
div_zero  output  1  sticky flag for the last divide: divisor was 0
hi  output  WIDTH  HI register (product high half / remainder)
lo  output  WIDTH  LO register (product low half / quotient)

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; counter cleared. Reset overrides everything, including mid-operation: the op is aborted and no hi/lo write occurs.
- States: IDLE, CALC, FIX.
- IDLE: if start=1, latch op/a/b, go to CALC, busy=1 next cycle. Signed ops latch |a|, |b| plus sign bits. For div, div_zero <= (b==0), cleared on any other accepted divide; unchanged by multiplies.
- CALC: one iteration per cycle, WIDTH cycles.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - Counter 0..WIDTH-1; on the last iteration go to FIX.
- FIX: apply sign correction, write hi/lo, done=1 for that one following cycle, busy=0, go to IDLE.
- Latency: start accepted at edge E0; hi/lo valid and done=1 after edge E0+WIDTH+1 (33 cycles for WIDTH=32). busy is high in exactly WIDTH+1 cycles.
- start while busy=1: ignored, no queueing. start in the done cycle: accepted (busy=0).
- Signed rules:
  - MULT: product negated iff sign(a)^sign(b).
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: no trap; lo = all ones, hi = a (original dividend); still takes full latency.
- Signed overflow (a = most-negative, b = -1, op=DIV): lo = most-negative, hi = 0.
- MTHI/MTLO:
  - hi_we/lo_we accepted only when busy=0 and not in FIX; they write hi/lo at the next edge.
  - Ignored while busy.
  - If asserted together with the FIX write, the FIX result wins.
  - Same-cycle start and hi_we: both happen; the later op result overwrites.
- hi/lo hold their value between writes; outputs are registered (no combinational path from inputs to hi/lo/done).

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> hi=0, lo=0, busy=0, done=0, div_zero=0; start asserted during rst is ignored.
- MULT (WIDTH=32), a=0xFFFFFFFE (-2), b=0x00000003 -> busy high 33 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2 -> lo=3, hi=1.
- DIVU a=0x12345678, b=0 -> div_zero=1, lo=0xFFFFFFFF, hi=0x12345678. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Handshake:
  - start re-pulsed mid-op -> ignored; result matches the first op.
  - rst asserted at iteration 10 -> busy=0 next cycle, hi=lo=0, no done pulse.
  - hi_we during busy -> no effect; hi_we=1, hi_in=0xA5A5A5A5 while idle -> hi=0xA5A5A5A5 next cycle.
- WIDTH=8 instance: MULT a=0x80, b=0x80 -> hi=0x40, lo=0x00, done after 9 cycles; DIV a=0x80, b=0xFF -> lo=0x80, hi=0x00.
